// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice.
//   NPC_*            : 2-bit next-PC select encodings driven by the control unit
//   PC_RESET_DEFAULT : default reset PC and base of the instruction window
//   ifu_state_e      : fetch-unit run/halt state
package mips_pkg;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_npc.sv
// Purely combinational next-PC selection and adder.
// Ports:
//   pc          in  32  registered PC
//   npc_op      in   2  next-PC select (SEQ/BRANCH/JUMP/JR)
//   br_taken    in   1  branch condition, only meaningful for BRANCH
//   imm16       in  16  signed branch offset in words
//   instr_index in  26  J-type target field
//   jr_target   in  32  register target for jr
//   npc         out 32  next PC candidate
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] br_off;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    // Word offset sign-extended and scaled to bytes; addition wraps mod 2^32.
    br_off   = $signed({{14{imm16[15]}}, imm16, 2'b00});
    npc      = pc_plus4;
    case (npc_op)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = br_taken ? (pc_plus4 + $unsigned(br_off)) : pc_plus4;
      NPC_JUMP:   npc = {pc[31:28], instr_index, 2'b00};
      NPC_JR:     npc = jr_target;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifu_pc.sv
// Instruction-fetch program counter for the single-cycle MIPS core.
// Holds the architectural PC, commits the next PC chosen by the control unit,
// and halts the core on a software request or on a bad fetch target.
// Ports:
//   clk, reset   in       clock, synchronous active-high reset
//   en           in   1   update enable (0 = stall)
//   halt_req     in   1   software halt request
//   npc_op       in   2   next-PC select
//   br_taken     in   1   branch condition
//   imm16        in  16   branch word offset
//   instr_index  in  26   J-type target field
//   jr_target    in  32   jr register target
//   pc           out 32   current PC
//   im_addr      out 32   pc - PC_RESET, instruction memory byte address
//   link         out 32   pc + 4 (jal/jalr write-back)
//   halted       out  1   core frozen in HALT
//   fault        out  1   sticky, HALT caused by a bad target
//   icount       out 32   committed PC update count
module ifu_pc
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        halt_req,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] im_addr,
  output logic [31:0] link,
  output logic        halted,
  output logic        fault,
  output logic [31:0] icount
);

  // Window bounds held at 33 bits so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] WIN_LO = {1'b0, PC_RESET};
  localparam logic [32:0] WIN_HI = WIN_LO + {1'b0, (32'(IM_WORDS) << 2)};

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] icount_q, icount_d;
  logic        fault_q, fault_d;
  logic [31:0] npc_w;
  logic        target_bad;
  logic        run_en;
  logic        commit;
  logic        set_fault;

  npc u_npc (
    .pc          (pc_q),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .npc         (npc_w)
  );

  always_comb begin
    target_bad = (npc_w[1:0] != 2'b00)
              || ({1'b0, npc_w} <  WIN_LO)
              || ({1'b0, npc_w} >= WIN_HI);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: halt_req or a bad committed target ends RUN; HALT is absorbing.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && en && (halt_req || target_bad)) state_d = ST_HALT;
  end

  // FSM outputs
  always_comb begin
    run_en    = (state_q == ST_RUN) && en;
    commit    = run_en && !halt_req && !target_bad;
    set_fault = run_en && !halt_req &&  target_bad;
    halted    = (state_q == ST_HALT);
  end

  always_comb begin
    pc_d     = commit ? npc_w : pc_q;
    icount_d = commit ? (icount_q + 32'd1) : icount_q;
    fault_d  = fault_q | set_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      icount_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      icount_q <= icount_d;
      fault_q  <= fault_d;
    end
  end

  assign pc      = pc_q;
  assign im_addr = pc_q - PC_RESET;
  assign link    = pc_q + 32'd4;
  assign fault   = fault_q;
  assign icount  = icount_q;

endmodule

// File: tb/tb_ifu_pc.sv
module tb_ifu_pc;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        halt_req = 1'b0;
  logic [1:0]  npc_op = NPC_SEQ;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, im_addr, link, icount;
  logic        halted, fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] im;
    logic [31:0] link;
    logic        halted;
    logic        fault;
    logic [31:0] icount;
  } obs_t;

  obs_t sb[$];

  ifu_pc #(.PC_RESET(32'h0000_3000), .IM_WORDS(1024)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .halt_req    (halt_req),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .pc          (pc),
    .im_addr     (im_addr),
    .link        (link),
    .halted      (halted),
    .fault       (fault),
    .icount      (icount)
  );

  always #5 clk = ~clk;

  function automatic obs_t ex(logic [31:0] p, logic h, logic f, logic [31:0] c);
    obs_t o;
    o.pc = p; o.im = p - 32'h3000; o.link = p + 32'd4;
    o.halted = h; o.fault = f; o.icount = c;
    return o;
  endfunction

  function automatic obs_t obs();
    obs_t o;
    o.pc = pc; o.im = im_addr; o.link = link;
    o.halted = halted; o.fault = fault; o.icount = icount;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("pc=%h im_addr=%h link=%h halted=%b fault=%b icount=%0d",
                     o.pc, o.im, o.link, o.halted, o.fault, o.icount);
  endfunction

  task automatic drive(input logic e, input logic hr, input logic [1:0] op,
                       input logic br, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr);
    en = e; halt_req = hr; npc_op = op; br_taken = br;
    imm16 = imm; instr_index = idx; jr_target = jr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, NPC_SEQ, 0, '0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    drive(1, 1, NPC_JR, 1, 16'h1234, 26'h3ff, 32'h1);
    reset = 1'b1;
    sb.push_back(ex(32'h3000, 0, 0, 0));
    tick();
    reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_seq();
    obs_t e;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
      sb.push_back(ex(32'h3000 + 32'(4 * i), 0, 0, 32'(i)));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL seq%0d: got %s, expected %s", i, fmt(obs()), fmt(e));
      end
    end
  endtask

  task automatic test_branch();
    obs_t e;
    do_reset();
    drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
    repeat (4) tick();
    // taken backward branch from 3010: 3014 - 16 = 3004
    drive(1, 0, NPC_BRANCH, 1, 16'hFFFC, '0, '0);
    sb.push_back(ex(32'h3004, 0, 0, 5));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL branch_taken: got %s, expected %s", fmt(obs()), fmt(e));
    end
    drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
    repeat (3) tick();
    drive(1, 0, NPC_BRANCH, 0, 16'hFFFC, '0, '0);
    sb.push_back(ex(32'h3014, 0, 0, 9));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL branch_not_taken: got %s, expected %s", fmt(obs()), fmt(e));
    end
    // forward taken branch from 3014: 3018 + 0x20 = 3038
    drive(1, 0, NPC_BRANCH, 1, 16'h0008, '0, '0);
    sb.push_back(ex(32'h3038, 0, 0, 10));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL branch_fwd: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_jump_jr();
    obs_t e;
    do_reset();
    drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
    repeat (8) tick();
    drive(1, 0, NPC_JUMP, 0, '0, 26'h0000C10, '0);
    sb.push_back(ex(32'h3040, 0, 0, 9));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL jump: got %s, expected %s", fmt(obs()), fmt(e));
    end
    drive(1, 0, NPC_JR, 0, '0, '0, 32'h3008);
    #1;
    checks++;
    if (link !== 32'h3044) begin
      errors++; $display("FAIL jr_link: got link=%h, expected link=%h", link, 32'h3044);
    end
    sb.push_back(ex(32'h3008, 0, 0, 10));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL jr: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_bad_target();
    obs_t e;
    // continues from pc=3008, icount=10
    drive(1, 0, NPC_JR, 0, '0, '0, 32'h3002);
    sb.push_back(ex(32'h3008, 1, 1, 10));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL jr_misaligned: got %s, expected %s", fmt(obs()), fmt(e));
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, (i == 2), (i == 1) ? NPC_JUMP : NPC_SEQ, 1, 16'h0004, 26'h0000C10, 32'h3000);
      sb.push_back(ex(32'h3008, 1, 1, 10));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL halt_absorb%0d: got %s, expected %s", i, fmt(obs()), fmt(e));
      end
    end
    drive(1, 1, NPC_SEQ, 0, '0, '0, '0);
    reset = 1'b1;
    sb.push_back(ex(32'h3000, 0, 0, 0));
    tick();
    reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_from_halt: got %s, expected %s", fmt(obs()), fmt(e));
    end
    drive(1, 0, NPC_JR, 0, '0, '0, 32'h2FFC);
    sb.push_back(ex(32'h3000, 1, 1, 0));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL jr_below_window: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_window_end();
    obs_t e;
    do_reset();
    drive(1, 0, NPC_JR, 0, '0, '0, 32'h3FFC);
    sb.push_back(ex(32'h3FFC, 0, 0, 1));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL jr_last_word: got %s, expected %s", fmt(obs()), fmt(e));
    end
    drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
    sb.push_back(ex(32'h3FFC, 1, 1, 1));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL seq_off_end: got %s, expected %s", fmt(obs()), fmt(e));
    end
    do_reset();
    drive(1, 0, NPC_JR, 0, '0, '0, 32'h3FFC);
    tick();
    drive(1, 0, NPC_BRANCH, 0, 16'hFFF0, '0, '0);
    sb.push_back(ex(32'h3FFC, 1, 1, 1));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL br_not_taken_off_end: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_halt_req();
    obs_t e;
    do_reset();
    drive(0, 1, NPC_SEQ, 0, '0, '0, '0);
    sb.push_back(ex(32'h3000, 0, 0, 0));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL halt_req_no_en: got %s, expected %s", fmt(obs()), fmt(e));
    end
    // halt_req outranks the bad target: halted but no fault
    drive(1, 1, NPC_JR, 0, '0, '0, 32'h3002);
    sb.push_back(ex(32'h3000, 1, 0, 0));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL halt_req: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  task automatic test_stall();
    obs_t e;
    do_reset();
    drive(1, 0, NPC_SEQ, 0, '0, '0, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, NPC_JUMP, 0, '0, 26'h0000C10, '0);
      sb.push_back(ex(32'h3004, 0, 0, 1));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin
        errors++; $display("FAIL stall%0d: got %s, expected %s", i, fmt(obs()), fmt(e));
      end
    end
    drive(0, 0, NPC_JR, 0, '0, '0, 32'h3001);
    sb.push_back(ex(32'h3004, 0, 0, 1));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL stall_bad_target: got %s, expected %s", fmt(obs()), fmt(e));
    end
    drive(0, 0, NPC_JUMP, 0, '0, 26'h0000C10, '0);
    reset = 1'b1;
    sb.push_back(ex(32'h3000, 0, 0, 0));
    tick();
    reset = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e) begin
      errors++; $display("FAIL reset_in_stall: got %s, expected %s", fmt(obs()), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump_jr();
    test_bad_target();
    test_window_end();
    test_halt_req();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
